rr_encoder_reg: RTL and testbench

- Registered round-robin priority encoder: converts an N-bit request vector into a binary index plus a matching one-hot grant.
- It is the counterpart to the team's binary-to-one-hot decoders. Use it wherever a request mask must be collapsed to an index fairly, e.g. TLB/cache way select, writeback port arbitration, exception source select.
- Single-entry output register with valid/ready handshake on both sides; one result per cycle when not back-pressured.

---
 rtl/rr_encoder_reg.sv | 62 ++++++
 tb/tb_rr_encoder_reg.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/rr_encoder_reg.sv
// Registered round-robin priority encoder: collapses a request vector to a binary
// index plus one-hot grant, with a single-entry valid/ready output register.
module rr_encoder_reg #(
    parameter int N = 16,
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         resetn,
    input  logic         in_valid,
    input  logic [N-1:0] in_req,
    output logic         in_ready,
    output logic         out_valid,
    output logic [W-1:0] out_idx,
    output logic [N-1:0] out_onehot,
    output logic         out_none,
    input  logic         out_ready
);

    logic [W-1:0] ptr;
    logic [W-1:0] sel_idx;
    logic         sel_found;
    logic         accept;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    // Walk the request vector starting at ptr; W-bit addition gives the wrap for free.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        sel_idx   = '0;
        sel_found = 1'b0;
        for (int i = 0; i < N; i++) begin
            if (!sel_found && in_req[ptr + W'(i)]) begin
                sel_found = 1'b1;
                sel_idx   = ptr + W'(i);
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update from pre-edge values.
        if (!resetn) begin
            out_valid  <= 1'b0;
            out_idx    <= '0;
            out_onehot <= '0;
            out_none   <= 1'b0;
            ptr        <= '0;
        end else if (accept) begin
            out_valid  <= 1'b1;
            out_idx    <= sel_found ? sel_idx : '0;
            out_onehot <= sel_found ? (N'(1) << sel_idx) : '0;
            out_none   <= !sel_found;
            // A zero vector leaves the pointer where it was.
            if (sel_found) begin
                ptr <= sel_idx + W'(1);
            end
        end else if (out_valid && out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_rr_encoder_reg.sv
// Self-checking bench for rr_encoder_reg: directed vector table, hand-written
// reset sequences, and randomized traffic against a round-robin reference model.
module tb_rr_encoder_reg;

    localparam int N = 16;
    localparam int W = 4;

    logic         clk = 1'b0;
    logic         resetn;
    logic         in_valid;
    logic [N-1:0] in_req;
    logic         in_ready;
    logic         out_valid;
    logic [W-1:0] out_idx;
    logic [N-1:0] out_onehot;
    logic         out_none;
    logic         out_ready;

    int errors = 0;
    int checks = 0;

    rr_encoder_reg #(.N(N), .W(W)) dut (
        .clk        (clk),
        .resetn     (resetn),
        .in_valid   (in_valid),
        .in_req     (in_req),
        .in_ready   (in_ready),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .out_onehot (out_onehot),
        .out_none   (out_none),
        .out_ready  (out_ready)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [15:0] req;
        logic        ordy;
        logic        exp_rdy;
        logic        exp_valid;
        logic        chk_data;
        logic [3:0]  exp_idx;
        logic        exp_none;
        logic [15:0] exp_oh;
    } vec_t;

    vec_t tbl[20];

    // Reference model: pointer and output register as plain integers.
    int m_ptr   = 0;
    int m_idx   = 0;
    bit m_valid = 1'b0;
    bit m_none  = 1'b0;

    function automatic int rr_pick(input logic [N-1:0] req, input int p);
        for (int k = 0; k < N; k++) begin
            if (req[(p + k) % N]) return (p + k) % N;
        end
        return -1;
    endfunction

    function automatic bit model_ready(input bit ordy);
        return !m_valid || ordy;
    endfunction

    task automatic model_edge(input bit v, input logic [N-1:0] req, input bit ordy, input bit rst);
        int k;
        if (!rst) begin
            m_valid = 1'b0; m_idx = 0; m_none = 1'b0; m_ptr = 0;
        end else if (v && model_ready(ordy)) begin
            k = rr_pick(req, m_ptr);
            m_valid = 1'b1;
            if (k < 0) begin
                m_none = 1'b1; m_idx = 0;
            end else begin
                m_none = 1'b0; m_idx = k; m_ptr = (k + 1) % N;
            end
        end else if (m_valid && ordy) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic apply(input bit v, input logic [N-1:0] req, input bit ordy, input bit rst);
        in_valid  = v;
        in_req    = req;
        out_ready = ordy;
        resetn    = rst;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge(in_valid, in_req, out_ready, resetn);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'(m_valid));
        if (m_valid) begin
            check({tag, " out_idx"}, 32'(out_idx), 32'(m_idx));
            check({tag, " out_none"}, 32'(out_none), 32'(m_none));
            check({tag, " out_onehot"}, 32'(out_onehot), m_none ? 32'h0 : (32'h1 << m_idx));
            if (!out_none) check({tag, " onehot_vs_idx"}, 32'(out_onehot), 32'h1 << out_idx);
        end
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, " out_valid"}, 32'(out_valid), 32'h0);
        check({tag, " out_idx"}, 32'(out_idx), 32'h0);
        check({tag, " out_onehot"}, 32'(out_onehot), 32'h0);
        check({tag, " out_none"}, 32'(out_none), 32'h0);
    endtask

    function automatic logic [N-1:0] rand_req();
        logic [N-1:0] r;
        case ($urandom_range(0, 3))
            0: r = '0;
            1: r = N'(1) << $urandom_range(0, N - 1);
            2: r = N'($urandom);
            default: r = N'($urandom) & N'($urandom);
        endcase
        return r;
    endfunction

    initial begin
        // v, req, ordy, rdy, valid, chk, idx, none, onehot
        tbl[0]  = '{1'b1, 16'h0081, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 16'h0001};
        tbl[1]  = '{1'b1, 16'h0081, 1'b1, 1'b1, 1'b1, 1'b1, 4'd7,  1'b0, 16'h0080};
        tbl[2]  = '{1'b1, 16'h0081, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 16'h0001};
        tbl[3]  = '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[4]  = '{1'b1, 16'h0000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1'b1, 16'h0000};
        tbl[5]  = '{1'b1, 16'hFFFF, 1'b1, 1'b1, 1'b1, 1'b1, 4'd5,  1'b0, 16'h0020};
        tbl[6]  = '{1'b1, 16'h0010, 1'b1, 1'b1, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[7]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[8]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[9]  = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[10] = '{1'b1, 16'h0100, 1'b0, 1'b0, 1'b1, 1'b1, 4'd4,  1'b0, 16'h0010};
        tbl[11] = '{1'b1, 16'h0100, 1'b1, 1'b1, 1'b1, 1'b1, 4'd8,  1'b0, 16'h0100};
        tbl[12] = '{1'b1, 16'h4000, 1'b1, 1'b1, 1'b1, 1'b1, 4'd14, 1'b0, 16'h4000};
        tbl[13] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1, 4'd15, 1'b0, 16'h8000};
        tbl[14] = '{1'b1, 16'h8001, 1'b1, 1'b1, 1'b1, 1'b1, 4'd0,  1'b0, 16'h0001};
        tbl[15] = '{1'b0, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000};
        tbl[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000};
        tbl[17] = '{1'b1, 16'h0006, 1'b0, 1'b1, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0002};
        tbl[18] = '{1'b1, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b1, 4'd1,  1'b0, 16'h0002};
        tbl[19] = '{1'b1, 16'h0006, 1'b1, 1'b1, 1'b1, 1'b1, 4'd2,  1'b0, 16'h0004};

        // Power-on reset.
        apply(1'b1, 16'hFFFF, 1'b1, 1'b0);
        tick();
        tick();
        check_reset_state("reset");

        // Directed table: reset sequence, zero vector, back-pressure, wrap, consume-only.
        for (int i = 0; i < 20; i++) begin
            apply(tbl[i].v, tbl[i].req, tbl[i].ordy, 1'b1);
            check($sformatf("tbl[%0d] in_ready", i), 32'(in_ready), 32'(tbl[i].exp_rdy));
            tick();
            check($sformatf("tbl[%0d] out_valid", i), 32'(out_valid), 32'(tbl[i].exp_valid));
            if (tbl[i].chk_data) begin
                check($sformatf("tbl[%0d] out_idx", i), 32'(out_idx), 32'(tbl[i].exp_idx));
                check($sformatf("tbl[%0d] out_none", i), 32'(out_none), 32'(tbl[i].exp_none));
                check($sformatf("tbl[%0d] out_onehot", i), 32'(out_onehot), 32'(tbl[i].exp_oh));
            end
        end

        // Mid-operation reset while a result is held under back-pressure.
        apply(1'b1, 16'h0003, 1'b0, 1'b1);
        check("midrst stall in_ready", 32'(in_ready), 32'h0);
        tick();
        check("midrst held out_idx", 32'(out_idx), 32'h2);
        apply(1'b1, 16'h0003, 1'b0, 1'b0);
        tick();
        check_reset_state("midrst");
        apply(1'b1, 16'h0003, 1'b1, 1'b1);
        check("midrst in_ready", 32'(in_ready), 32'h1);
        tick();
        check("midrst 0003 out_idx", 32'(out_idx), 32'h0);
        check("midrst 0003 out_valid", 32'(out_valid), 32'h1);

        // Second reset with ptr=1, then a full vector must grant index 0.
        apply(1'b0, 16'h0000, 1'b1, 1'b0);
        tick();
        apply(1'b1, 16'hFFFF, 1'b1, 1'b1);
        tick();
        check("rst2 FFFF out_idx", 32'(out_idx), 32'h0);
        check("rst2 FFFF out_onehot", 32'(out_onehot), 32'h1);

        // Streaming: one result per cycle, compared to the model.
        for (int i = 0; i < 32; i++) begin
            apply(1'b1, rand_req(), 1'b1, 1'b1);
            check("stream in_ready", 32'(in_ready), 32'h1);
            tick();
            check("stream out_valid", 32'(out_valid), 32'h1);
            check_model("stream");
        end

        // Random handshakes with back-pressure and idle cycles.
        for (int i = 0; i < 300; i++) begin
            apply(($urandom_range(0, 3) != 0), rand_req(), ($urandom_range(0, 2) != 0), 1'b1);
            check("random in_ready", 32'(in_ready), 32'(model_ready(out_ready)));
            tick();
            check_model("random");
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
